// File: rtl/radix8_booth_mult_seq.sv
// Sequential signed N x N multiplier using radix-8 Booth recoding, one digit per clock.
// A reset pulse arms a new multiplication; the product appears 1+K edges after release.
module radix8_booth_mult_seq #(
    parameter int N = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] Prod
);

    localparam int K  = (N + 2) / 3;
    localparam int AW = 2 * N + 3;
    localparam int BW = 3 * K;
    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {LOAD, ITER, DONE} state_t;

    state_t        state, state_next;
    logic [AW-1:0] m, m3, acc;
    logic [N-1:0]  b_reg;
    logic [CW-1:0] cnt;
    logic [BW:0]   b_ext;
    logic [3:0]    digit;
    logic [AW-1:0] mag, pp, pp_shift, acc_next;
    logic          neg, last;

    // Multiplier sign-extended to whole digits with the implicit b[-1] = 0 appended.
    assign b_ext    = {BW'(signed'(b_reg)), 1'b0};
    assign digit    = b_ext[3*cnt +: 4];
    assign last     = (cnt == CW'(K - 1));
    assign pp       = neg ? (~mag + 1'b1) : mag;
    assign pp_shift = pp << (3 * cnt);
    assign acc_next = acc + pp_shift;

    always_comb begin
        // NOTE: defaults first so every path assigns mag/neg and no latch is inferred.
        mag = '0;
        neg = 1'b0;
        unique case (digit)
            4'b0001, 4'b0010: mag = m;
            4'b0011:          mag = m << 1;
            4'b0100:          mag = m << 1;
            4'b0101, 4'b0110: mag = m3;
            4'b0111:          mag = m << 2;
            4'b1000:          begin mag = m << 2; neg = 1'b1; end
            4'b1001, 4'b1010: begin mag = m3;     neg = 1'b1; end
            4'b1011, 4'b1100: begin mag = m << 1; neg = 1'b1; end
            4'b1101, 4'b1110: begin mag = m;      neg = 1'b1; end
            default:          mag = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            LOAD:    state_next = ITER;
            ITER:    if (last) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m     <= '0;
            m3    <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            Prod  <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    m     <= AW'(signed'(a));
                    m3    <= AW'(signed'(a)) + (AW'(signed'(a)) << 1);
                    b_reg <= b;
                    acc   <= '0;
                    cnt   <= '0;
                end
                ITER: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (last) Prod <= acc_next[2*N-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_radix8_booth_mult_seq.sv
// Directed bench for radix8_booth_mult_seq (N=9): latency, corner products, sweep, async abort.
module tb_radix8_booth_mult_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  a, b;
    logic [17:0] Prod;

    int tests = 0;
    int fails = 0;

    radix8_booth_mult_seq #(.N(9)) dut (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .Prod (Prod)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Apply operands, pulse reset for one cycle, then check latency and product.
    task automatic mult(input int av, input int bv, input int expv, input bit check_zero, input string tag);
        @(negedge clk);
        a     = 9'(av);
        b     = 9'(bv);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            if (check_zero) check({tag, " early"}, Prod, 18'd0);
        end
        @(posedge clk); #1;
        check(tag, Prod, 18'(expv));
    endtask

    initial begin
        a = '0;
        b = '0;
        reset = 1'b1;
        #1;
        check("reset_prod", Prod, 18'd0);
        repeat (2) @(negedge clk);

        // Basic product, then hold in DONE.
        mult(7, -3, -21, 1'b1, "7x-3");
        repeat (8) @(posedge clk);
        #1 check("7x-3 hold", Prod, 18'(-21));

        // Range corners.
        mult(-256, -256, 65536, 1'b1, "min_x_min");
        mult(-256, 255, -65280, 1'b1, "min_x_max");
        mult(255, 255, 65025, 1'b1, "max_x_max");

        // Digit coverage including +/-3M.
        mult(-5, 227, -1135, 1'b1, "-5x227");
        mult(13, -1, -13, 1'b1, "13x-1");
        mult(-200, 0, 0, 1'b1, "-200x0");
        mult(-3, 173, -519, 1'b1, "-3x173");
        mult(11, -170, -1870, 1'b1, "11x-170");

        // Exhaustive small-range sweep.
        for (int i = -16; i <= 15; i++)
            for (int j = -16; j <= 15; j++)
                mult(i, j, i * j, 1'b0, "sweep");

        // Random sample over the full operand range.
        for (int r = 0; r < 200; r++) begin
            int ra, rb;
            ra = $urandom_range(511) - 256;
            rb = $urandom_range(511) - 256;
            mult(ra, rb, ra * rb, 1'b0, "random");
        end

        // Mid-operation abort: reset asserted between edges clears asynchronously.
        @(negedge clk);
        a = 9'd100;
        b = 9'd100;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1 check("abort_clear", Prod, 18'd0);
        mult(3, -4, -12, 1'b1, "abort_restart");

        // Operands changed after DONE are ignored; reset alone clears.
        mult(7, 11, 77, 1'b1, "7x11");
        @(negedge clk);
        a = 9'd1;
        b = 9'd1;
        repeat (8) @(posedge clk);
        #1 check("done_ignores_ops", Prod, 18'd77);
        #2 reset = 1'b1;
        #1 check("done_async_clear", Prod, 18'd0);

        // Long reset keeps everything cleared, then a normal run follows.
        repeat (3) @(posedge clk);
        #1 check("long_reset", Prod, 18'd0);
        mult(-9, 8, -72, 1'b1, "after_long_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
